instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000, as the first fetch address after reset.
REQ-002 The block SHALL take parameter BUF_DEPTH, default 2, as the instruction buffer entry count; only 2 is supported.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port imem_req, output, 1: fetch request valid.
REQ-006 Port imem_addr, output, 32: fetch address, word-aligned.
REQ-007 Port imem_gnt, input, 1: memory accepts the request this cycle.
REQ-008 Port imem_rvalid, input, 1: read data valid.
REQ-009 Port imem_rdata, input, 32: instruction word.
REQ-010 Port redirect_valid, input, 1: taken branch or jump from the execute stage.
REQ-011 Port redirect_pc, input, 32: target address; bits [1:0] SHALL be ignored.
REQ-012 Port instr_valid, output, 1: instruction presented to the decoder.
REQ-013 Port instr_ready, input, 1: decoder consumes the instruction.
REQ-014 Port instr, output, 32: instruction word; SHALL read 32'h0000_0013 (NOP) whenever instr_valid=0.
REQ-015 Port instr_pc, output, 32: address of instr.
REQ-016 Port instr_pc_plus4, output, 32: instr_pc+4, modulo 2^32.

Function
REQ-017 The block SHALL allow at most one outstanding memory transaction.
REQ-018 The FSM SHALL have three states: ISSUE (imem_req asserted), WAIT (granted, awaiting rvalid) and DROP (awaiting a stale rvalid).
REQ-019 In ISSUE, imem_req SHALL be 1 only when buffer occupancy is less than BUF_DEPTH; imem_addr SHALL equal fetch_pc.
REQ-020 On ISSUE with imem_gnt=1, the FSM SHALL go to WAIT, latch the request address and set fetch_pc to fetch_pc+4 (wraps at 2^32).
REQ-021 In WAIT, imem_rvalid=1 SHALL write {rdata, latched address} into the buffer and return the FSM to ISSUE.
REQ-022 Latency: data SHALL appear on instr with instr_valid=1 in the cycle after imem_rvalid when the buffer was empty.
REQ-023 The buffer SHALL be a FIFO; an entry SHALL pop when instr_valid and instr_ready are both 1; a push and a pop in the same cycle SHALL both occur.
REQ-024 imem_req and imem_addr SHALL remain stable while imem_req=1 and imem_gnt=0, except on redirect.
REQ-025 On redirect_valid=1, the next cycle SHALL show: buffer empty, instr_valid=0, and fetch_pc={redirect_pc[31:2],2'b00}.
REQ-026 Redirect in ISSUE without grant: the request SHALL be withdrawn and the FSM SHALL stay in ISSUE.
REQ-027 Redirect in ISSUE with grant in the same cycle: the FSM SHALL go to DROP.
REQ-028 Redirect in WAIT without rvalid: the FSM SHALL go to DROP.
REQ-029 Redirect in WAIT with rvalid in the same cycle: the data SHALL be discarded and the FSM SHALL go to ISSUE.
REQ-030 In DROP, imem_req SHALL be 0; rvalid data SHALL be discarded, then the FSM SHALL go to ISSUE.
REQ-031 A redirect in DROP SHALL update fetch_pc and the FSM SHALL remain in DROP.
REQ-032 A redirect SHALL take priority over a same-cycle buffer push or pop; the pop is still counted as consumed by the decoder.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL set: fetch_pc=RESET_PC, FSM=ISSUE, buffer empty.
REQ-034 While rst_n=0, outputs SHALL be held: imem_req=0, instr_valid=0, instr=NOP.
REQ-035 An outstanding transaction aborted by reset SHALL be dropped; the memory side is reset together with this block.

Structure
REQ-036 Shared package riscv_pkg SHALL hold: NOP_INSTR, XLEN=32, default RESET_PC, and the fetch FSM state enum.
REQ-037 The buffer SHALL be sub-module fetch_fifo: 2 entries, 64-bit payload {pc, instr}, with a flush input.

Verification
REQ-038 Reset then a zero-wait memory (gnt=1, rvalid the next cycle): addresses 0,4,8 SHALL be fetched in order; instr_pc sequence 0,4,8; instr_pc_plus4 of the first instruction = 4.
REQ-039 instr_ready=0 for 10 cycles: after two buffered entries imem_req SHALL drop to 0; releasing ready SHALL deliver pc 0 and 4 in order with none lost.
REQ-040 Redirect to 32'h0000_0103 while in WAIT: stale rdata SHALL be dropped and the next instr_pc SHALL be 32'h0000_0100.
REQ-041 Redirect in the same cycle as gnt, with rvalid 3 cycles later: no instr_valid from the old address; the next request address SHALL be the target.
REQ-042 RESET_PC=32'hFFFF_FFFC: after the first fetch, imem_addr SHALL wrap to 32'h0000_0000 and instr_pc_plus4 SHALL be 0.
REQ-043 rst_n low mid-WAIT for 1 cycle: instr_valid SHALL be 0 and refetch SHALL start at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch FSM state type
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DROP  = 2'd2
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry instruction buffer with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count_q != 2'd0);
  assign full      = (count_q == 2'(DEPTH));
  // A push into a full buffer is allowed only when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && not_empty;
  assign head_data = mem[rd_ptr];
  assign count     = count_q;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] req_addr_d;

  logic            buf_push;
  logic            buf_pop;
  logic            buf_valid;
  logic [1:0]      buf_count;
  logic [63:0]     buf_head;
  logic            can_issue;

  // Only request when the response is guaranteed a free buffer slot.
  assign can_issue = (buf_count < 2'(BUF_DEPTH));

  // FSM, fetch address and in-flight address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_ISSUE;
      fetch_pc_q <= align_pc(RESET_PC);
      req_addr_q <= align_pc(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next state, request generation and buffer write decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    imem_req   = 1'b0;
    buf_push   = 1'b0;
    case (state_q)
      FETCH_ISSUE: begin
        imem_req = rst_n && can_issue;
        if (imem_req && imem_gnt) begin
          req_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // A granted request racing a redirect still returns data we must swallow.
          state_d    = redirect_valid ? FETCH_DROP : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          buf_push = !redirect_valid;
          state_d  = FETCH_ISSUE;
        end else if (redirect_valid) begin
          state_d  = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        if (imem_rvalid) state_d = FETCH_ISSUE;
      end
      default: state_d = FETCH_ISSUE;
    endcase
    if (redirect_valid) fetch_pc_d = align_pc(redirect_pc);
  end

  assign buf_pop = instr_valid && instr_ready;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data ({req_addr_q, imem_rdata}),
    .pop       (buf_pop),
    .head_data (buf_head),
    .not_empty (buf_valid),
    .count     (buf_count)
  );

  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = rst_n && buf_valid;
  assign instr          = instr_valid ? buf_head[31:0] : NOP_INSTR;
  assign instr_pc       = buf_head[63:32];
  assign instr_pc_plus4 = buf_head[63:32] + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, redirect_valid, instr_valid, instr_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic [31:0] imem_addr, redirect_pc, instr, instr_pc, instr_pc_plus4;

  logic        w_req, w_gnt, w_rvalid, w_valid, w_ready, w_redirect;
  logic [31:0] w_addr, w_rdata, w_redirect_pc, w_instr, w_pc, w_pc4;

  int n_cmp = 0;
  int n_bad = 0;
  int grants_left = 0;
  int mem_lat = 1;
  logic [31:0] granted[$];
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  assign imem_gnt = (grants_left > 0);

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr),
    .instr_pc(w_pc), .instr_pc_plus4(w_pc4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [31:0] exp);
    logic [31:0] a;
    a = 32'hxxxx_xxxx;
    if (granted.size() != 0) a = granted.pop_front();
    chk(tag, a, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_push(input logic [31:0] pc);
    sb.push_back({pc, mem_word(pc)});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Memory model: samples the handshake mid-cycle, answers mem_lat cycles after a grant.
  logic        hs_s, rv_s, rst_s;
  logic [31:0] hs_addr_s;
  logic        pending = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  always @(negedge clk) begin
    hs_s      = imem_req && imem_gnt;
    rv_s      = imem_rvalid;
    rst_s     = rst_n;
    hs_addr_s = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (rst_s !== 1'b1) begin
      pending     = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      if (rv_s === 1'b1) pending = 1'b0;
      if (hs_s === 1'b1) begin
        pending = 1'b1;
        cnt     = mem_lat;
        paddr   = hs_addr_s;
        granted.push_back(hs_addr_s);
        if (grants_left > 0) grants_left = grants_left - 1;
      end
      if (pending) begin
        cnt         = cnt - 1;
        imem_rvalid = (cnt == 0);
        imem_rdata  = (cnt == 0) ? mem_word(paddr) : 32'hDEAD_BEEF;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Decoder-side scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk1("unexpected_instr_valid", instr_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("sb_instr_pc", instr_pc, e[63:32]);
        chk("sb_instr", instr, e[31:0]);
        chk("sb_instr_pc_plus4", instr_pc_plus4, e[63:32] + 32'd4);
      end
    end
    if (instr_valid !== 1'b1) chk("nop_when_idle", instr, NOP_INSTR);
  end

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0; w_ready = 1'b0;
    w_redirect = 1'b0; w_redirect_pc = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Zero-wait streaming of three words.
    tick();
    rst_n = 1'b1; instr_ready = 1'b1; mem_lat = 1; grants_left = 3;
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
    @(negedge clk);
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    drain("stream_drain");
    chk_grant("stream_grant0", 32'h0);
    chk_grant("stream_grant4", 32'h4);
    chk_grant("stream_grant8", 32'h8);
    @(negedge clk);
    chk1("hold_req", imem_req, 1'b1);
    chk("hold_addr", imem_addr, 32'hC);
    tick();
    @(negedge clk);
    chk("hold_addr2", imem_addr, 32'hC);

    // Redirect in ISSUE without grant.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0406;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("issue_redir_addr", imem_addr, 32'h0000_0404);
    chk1("issue_redir_req", imem_req, 1'b1);

    // Backpressure: buffer fills, request drops, nothing lost.
    do_reset();
    instr_ready = 1'b0; mem_lat = 1; grants_left = 5;
    exp_push(32'h0); exp_push(32'h4);
    repeat (10) tick();
    @(negedge clk);
    chk1("full_req_drop", imem_req, 1'b0);
    chk1("full_valid", instr_valid, 1'b1);
    chk("full_head_pc", instr_pc, 32'h0);
    chk("full_grant_count", 32'(granted.size()), 32'd2);
    tick();
    grants_left = 0; instr_ready = 1'b1;
    drain("bp_drain");
    chk_grant("bp_grant0", 32'h0);
    chk_grant("bp_grant4", 32'h4);

    // Redirect while waiting; stale data arrives in DROP.
    do_reset();
    mem_lat = 3; grants_left = 1;
    @(negedge clk);
    chk1("wr_c0_req", imem_req, 1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk1("wr_wait_req", imem_req, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk1("wr_drop_valid", instr_valid, 1'b0);
    chk1("wr_drop_req", imem_req, 1'b0);
    chk("wr_fetch_pc", imem_addr, 32'h0000_0100);
    tick();
    @(negedge clk);
    chk1("wr_stale_req", imem_req, 1'b0);
    tick();
    exp_push(32'h0000_0100); grants_left = 1; mem_lat = 1;
    @(negedge clk);
    chk1("wr_reissue_req", imem_req, 1'b1);
    chk("wr_reissue_addr", imem_addr, 32'h0000_0100);
    drain("wr_drain");
    chk_grant("wr_grant_old", 32'h0);
    chk_grant("wr_grant_new", 32'h0000_0100);

    // Redirect in WAIT coinciding with rvalid.
    do_reset();
    mem_lat = 1; grants_left = 1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk1("wrv_req", imem_req, 1'b1);
    chk("wrv_addr", imem_addr, 32'h0000_0300);
    chk1("wrv_valid", instr_valid, 1'b0);
    tick();
    @(negedge clk);
    chk1("wrv_valid2", instr_valid, 1'b0);
    chk_grant("wrv_grant", 32'h0);

    // Redirect in the same cycle as grant; response three cycles later.
    do_reset();
    mem_lat = 3; grants_left = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    chk1("gr_c0_req", imem_req, 1'b1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk1("gr_drop_req", imem_req, 1'b0);
    chk("gr_drop_addr", imem_addr, 32'h0000_0200);
    repeat (3) tick();
    exp_push(32'h0000_0200); grants_left = 1; mem_lat = 1;
    @(negedge clk);
    chk1("gr_reissue_req", imem_req, 1'b1);
    chk("gr_reissue_addr", imem_addr, 32'h0000_0200);
    drain("gr_drain");
    chk_grant("gr_grant_old", 32'h0);
    chk_grant("gr_grant_new", 32'h0000_0200);

    // Reset pulse in the middle of WAIT.
    do_reset();
    mem_lat = 3; grants_left = 1;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk1("rw_rst_valid", instr_valid, 1'b0);
    chk1("rw_rst_req", imem_req, 1'b0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rw_refetch_req", imem_req, 1'b1);
    chk("rw_refetch_addr", imem_addr, 32'h0);
    repeat (2) tick();
    @(negedge clk);
    chk1("rw_no_stale", instr_valid, 1'b0);
    tick();
    exp_push(32'h0); grants_left = 1; mem_lat = 1;
    drain("rw_drain");
    chk_grant("rw_grant_aborted", 32'h0);
    chk_grant("rw_grant_refetch", 32'h0);

    // Address wrap with RESET_PC at the top of the space.
    @(negedge clk);
    chk1("wrap_req", w_req, 1'b1);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    w_gnt = 1'b1;
    tick();
    w_gnt = 1'b0;
    @(negedge clk);
    chk("wrap_next_addr", w_addr, 32'h0);
    chk1("wrap_wait_req", w_req, 1'b0);
    tick();
    w_rvalid = 1'b1; w_rdata = 32'h0040_0093;
    tick();
    w_rvalid = 1'b0;
    @(negedge clk);
    chk1("wrap_valid", w_valid, 1'b1);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, 32'h0040_0093);
    chk1("wrap_req2", w_req, 1'b1);
    chk("wrap_addr2", w_addr, 32'h0);

    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
